// File: rtl/iomemory_burst.sv
// iomemory_burst: single-clock data/vector I/O memory for the interpolation
// processor. Four address-decoded regions on addr[31:30]:
//   00 scalar data RAM, 01 source-image buffer, 10 destination VRAM, 11 I/O bank.
// A vector load engine bursts LANES source pixels into vld_data, and a vector
// store engine bursts LANES pixels into VRAM. A dual-pixel display port reads
// both image buffers without ever stalling.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   addr/wdata/we/re      scalar port; stall refuses an access this cycle
//   rdata/rvalid          scalar read data, valid one cycle after accepted re
//   buttons               raw buttons, readable at I/O offset 0
//   vld_req/vld_addr      vector load request and source start index
//   vld_valid/vld_ready   vector load result handshake, vld_data lane 0 in LSBs
//   vst_valid/vst_ready   vector store handshake, vst_addr/vst_data payload
//   disp_addr             display pixel index; disp_src/disp_dst 1 cycle later
//   err                   sticky error (we&re collision, protected write)
//
// Build option: define IOMEM_SRC_WP_EN to write-protect the source buffer
// from the scalar port (writes dropped, err set).

module iomemory_burst #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned LANES     = 16,
  parameter int unsigned RAM_DEPTH = 1024,
  parameter int unsigned IMG_DEPTH = 65536
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              addr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     we,
  input  logic                     re,
  output logic                     stall,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rvalid,
  input  logic [3:0]               buttons,
  input  logic                     vld_req,
  input  logic [31:0]              vld_addr,
  output logic                     vld_valid,
  input  logic                     vld_ready,
  output logic [LANES*PIX_W-1:0]   vld_data,
  input  logic                     vst_valid,
  output logic                     vst_ready,
  input  logic [31:0]              vst_addr,
  input  logic [LANES*PIX_W-1:0]   vst_data,
  input  logic [31:0]              disp_addr,
  output logic [PIX_W-1:0]         disp_src,
  output logic [PIX_W-1:0]         disp_dst,
  output logic                     err
);

  localparam int unsigned VEC_W  = LANES * PIX_W;
  localparam int unsigned RAM_AW = $clog2(RAM_DEPTH);
  localparam int unsigned IMG_AW = $clog2(IMG_DEPTH);
  localparam int unsigned CNT_W  = $clog2(LANES + 1);

  localparam logic [1:0] REG_RAM  = 2'b00;
  localparam logic [1:0] REG_SRC  = 2'b01;
  localparam logic [1:0] REG_VRAM = 2'b10;
  localparam logic [1:0] REG_IO   = 2'b11;

  localparam logic [1:0] LD_IDLE  = 2'd0;
  localparam logic [1:0] LD_LOAD  = 2'd1;
  localparam logic [1:0] LD_HOLD  = 2'd2;

  localparam logic       ST_IDLE  = 1'b0;
  localparam logic       ST_STORE = 1'b1;

  // Storage; contents survive reset.
  logic [DATA_W-1:0] ram_mem  [RAM_DEPTH];
  logic [PIX_W-1:0]  src_mem  [IMG_DEPTH];
  logic [PIX_W-1:0]  vram_mem [IMG_DEPTH];

  // Engine state
  logic [1:0]        ld_state, ld_next;
  logic [CNT_W-1:0]  ld_cnt;
  logic [IMG_AW-1:0] ld_base;
  logic [PIX_W-1:0]  ld_q;
  logic              ld_start_c;

  logic              st_state, st_next;
  logic [CNT_W-1:0]  st_cnt;
  logic [IMG_AW-1:0] st_base;
  logic [VEC_W-1:0]  st_data;

  // Scalar decode
  logic [1:0]        region_c;
  logic [RAM_AW-1:0] ram_idx_c;
  logic [IMG_AW-1:0] img_idx_c;
  logic [IMG_AW-1:0] ld_ridx_c;
  logic [IMG_AW-1:0] st_widx_c;
  logic [IMG_AW-1:0] disp_idx_c;
  logic              ld_busy_c, st_busy_c;
  logic              acc_c, wr_acc_c, rd_acc_c;
  logic              src_wr_c, wp_err_c;
  logic              err_set_c, err_clr_c;
  logic [DATA_W-1:0] rd_mux_c;

  assign region_c   = addr[31:30];
  assign ram_idx_c  = addr[RAM_AW-1:0];
  assign img_idx_c  = addr[IMG_AW-1:0];
  assign ld_ridx_c  = ld_base + IMG_AW'(ld_cnt);
  assign st_widx_c  = st_base + IMG_AW'(st_cnt);
  assign disp_idx_c = disp_addr[IMG_AW-1:0];

  assign ld_busy_c  = (ld_state != LD_IDLE);
  assign st_busy_c  = (st_state != ST_IDLE);

  // A scalar access collides with an engine that owns that buffer's port.
  assign stall    = (we | re) &
                    (((region_c == REG_SRC)  & ld_busy_c) |
                     ((region_c == REG_VRAM) & st_busy_c));
  assign acc_c    = (we | re) & ~stall;
  assign wr_acc_c = acc_c & we;
  // A simultaneous we&re performs only the write.
  assign rd_acc_c = acc_c & re & ~we;

`ifdef IOMEM_SRC_WP_EN
  assign src_wr_c = 1'b0;
  assign wp_err_c = wr_acc_c & (region_c == REG_SRC);
`else
  assign src_wr_c = wr_acc_c & (region_c == REG_SRC);
  assign wp_err_c = 1'b0;
`endif

  assign err_set_c = (acc_c & we & re) | wp_err_c;
  assign err_clr_c = wr_acc_c & (region_c == REG_IO) & (addr[1:0] == 2'd1) & wdata[0];

  assign vst_ready = (st_state == ST_IDLE);

  // Address bits above each region's index width are don't-care.
  logic unused_bits;
  assign unused_bits = ^{addr, vld_addr, vst_addr, disp_addr, wdata};

  // Scalar read data selection
  always_comb begin
    rd_mux_c = '0;
    case (region_c)
      REG_RAM:  rd_mux_c = ram_mem[ram_idx_c];
      REG_SRC:  rd_mux_c = DATA_W'(src_mem[img_idx_c]);
      REG_VRAM: rd_mux_c = DATA_W'(vram_mem[img_idx_c]);
      default: begin
        case (addr[1:0])
          2'd0:    rd_mux_c = DATA_W'(buttons);
          2'd1:    rd_mux_c = DATA_W'({err, ld_busy_c, st_busy_c});
          default: rd_mux_c = '0;
        endcase
      end
    endcase
  end

  // Load engine state register
  always_ff @(posedge clk) begin
    if (!rst_n) ld_state <= LD_IDLE;
    else        ld_state <= ld_next;
  end

  // Load engine next state
  always_comb begin
    ld_next = ld_state;
    case (ld_state)
      LD_IDLE: if (vld_req) ld_next = LD_LOAD;
      LD_LOAD: if (ld_cnt == CNT_W'(LANES)) ld_next = LD_HOLD;
      LD_HOLD: if (vld_ready) ld_next = vld_req ? LD_LOAD : LD_IDLE;
      default: ld_next = LD_IDLE;
    endcase
  end

  assign ld_start_c = (ld_next == LD_LOAD) && (ld_state != LD_LOAD);

  // Load datapath: read pixel cnt, shift previous read in at the top so
  // lane 0 ends in the LSBs after LANES shifts; one drain cycle at the end.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_cnt    <= '0;
      ld_base   <= '0;
      ld_q      <= '0;
      vld_data  <= '0;
      vld_valid <= 1'b0;
    end else begin
      vld_valid <= (ld_next == LD_HOLD);
      if (ld_start_c) begin
        ld_base <= vld_addr[IMG_AW-1:0];
        ld_cnt  <= '0;
      end else if (ld_state == LD_LOAD) begin
        if (ld_cnt != '0)
          vld_data <= VEC_W'({ld_q, vld_data} >> PIX_W);
        if (ld_cnt < CNT_W'(LANES))
          ld_q <= src_mem[ld_ridx_c];
        if (ld_cnt != CNT_W'(LANES))
          ld_cnt <= ld_cnt + CNT_W'(1);
      end
    end
  end

  // Store engine state register
  always_ff @(posedge clk) begin
    if (!rst_n) st_state <= ST_IDLE;
    else        st_state <= st_next;
  end

  // Store engine next state
  always_comb begin
    st_next = st_state;
    case (st_state)
      ST_IDLE:  if (vst_valid) st_next = ST_STORE;
      ST_STORE: if (st_cnt == CNT_W'(LANES - 1)) st_next = ST_IDLE;
      default:  st_next = ST_IDLE;
    endcase
  end

  // Store datapath: lane 0 is always at the bottom of the shifting copy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_cnt  <= '0;
      st_base <= '0;
      st_data <= '0;
    end else if (vst_ready && vst_valid) begin
      st_base <= vst_addr[IMG_AW-1:0];
      st_data <= vst_data;
      st_cnt  <= '0;
    end else if (st_state == ST_STORE) begin
      st_data <= st_data >> PIX_W;
      st_cnt  <= st_cnt + CNT_W'(1);
    end
  end

  // Memory writes; suppressed during reset so an aborted burst stops cleanly.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (wr_acc_c && (region_c == REG_RAM))
        ram_mem[ram_idx_c] <= wdata;
      if (src_wr_c)
        src_mem[img_idx_c] <= wdata[PIX_W-1:0];
      if (st_state == ST_STORE)
        vram_mem[st_widx_c] <= st_data[PIX_W-1:0];
      else if (wr_acc_c && (region_c == REG_VRAM))
        vram_mem[img_idx_c] <= wdata[PIX_W-1:0];
    end
  end

  // Scalar read, display port and sticky error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata    <= '0;
      rvalid   <= 1'b0;
      disp_src <= '0;
      disp_dst <= '0;
      err      <= 1'b0;
    end else begin
      rvalid <= rd_acc_c;
      if (rd_acc_c) rdata <= rd_mux_c;
      disp_src <= src_mem[disp_idx_c];
      disp_dst <= vram_mem[disp_idx_c];
      err      <= (err & ~err_clr_c) | err_set_c;
    end
  end

endmodule

// File: tb/tb_iomemory_burst.sv
// Self-checking bench for iomemory_burst: a vector table of scalar accesses,
// hand sequences for bursts, stalls, wrap and reset, then randomized
// operations compared with an array-based reference model.

module tb_iomemory_burst;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned PIX_W     = 8;
  localparam int unsigned LANES     = 16;
  localparam int unsigned RAM_DEPTH = 1024;
  localparam int unsigned IMG_DEPTH = 65536;
  localparam int unsigned VEC_W     = LANES * PIX_W;
  localparam int unsigned RAM_AW    = $clog2(RAM_DEPTH);
  localparam int unsigned IMG_AW    = $clog2(IMG_DEPTH);
`ifdef IOMEM_SRC_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic clk, rst_n;
  logic [31:0] addr;
  logic [DATA_W-1:0] wdata, rdata;
  logic we, re, stall, rvalid;
  logic [3:0] buttons;
  logic vld_req, vld_valid, vld_ready;
  logic [31:0] vld_addr, vst_addr, disp_addr;
  logic [VEC_W-1:0] vld_data, vst_data;
  logic vst_valid, vst_ready;
  logic [PIX_W-1:0] disp_src, disp_dst;
  logic err;

  iomemory_burst #(
    .DATA_W(DATA_W), .PIX_W(PIX_W), .LANES(LANES),
    .RAM_DEPTH(RAM_DEPTH), .IMG_DEPTH(IMG_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .stall(stall), .rdata(rdata), .rvalid(rvalid), .buttons(buttons),
    .vld_req(vld_req), .vld_addr(vld_addr), .vld_valid(vld_valid),
    .vld_ready(vld_ready), .vld_data(vld_data), .vst_valid(vst_valid),
    .vst_ready(vst_ready), .vst_addr(vst_addr), .vst_data(vst_data),
    .disp_addr(disp_addr), .disp_src(disp_src), .disp_dst(disp_dst), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain arrays plus "written" flags.
  logic [31:0] ram_m  [RAM_DEPTH];
  bit          ram_k  [RAM_DEPTH];
  logic [7:0]  src_m  [IMG_DEPTH];
  bit          src_k  [IMG_DEPTH];
  logic [7:0]  vram_m [IMG_DEPTH];
  bit          vram_k [IMG_DEPTH];
  bit          err_m;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string nm, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int win(input int depth, input int r);
    return (depth - 32 + r) % depth;
  endfunction

  // Build a region address with random don't-care upper bits.
  function automatic logic [31:0] mk_addr(input logic [1:0] region, input int idx);
    logic [31:0] a;
    a = $urandom;
    a[31:30] = region;
    if (region == 2'b00) a[RAM_AW-1:0] = RAM_AW'(idx);
    else                 a[IMG_AW-1:0] = IMG_AW'(idx);
    return a;
  endfunction

  task automatic mdl_write(input logic [31:0] a, input logic [31:0] d);
    int i;
    case (a[31:30])
      2'b00: begin i = int'(a % RAM_DEPTH); ram_m[i] = d; ram_k[i] = 1'b1; end
      2'b01: begin
        i = int'(a % IMG_DEPTH);
        if (WP) err_m = 1'b1;
        else begin src_m[i] = d[7:0]; src_k[i] = 1'b1; end
      end
      2'b10: begin i = int'(a % IMG_DEPTH); vram_m[i] = d[7:0]; vram_k[i] = 1'b1; end
      default: if ((a % 4) == 1 && d[0]) err_m = 1'b0;
    endcase
  endtask

  task automatic mdl_read(input logic [31:0] a, output logic [31:0] v, output bit k);
    int i;
    k = 1'b1;
    v = '0;
    case (a[31:30])
      2'b00: begin i = int'(a % RAM_DEPTH); v = ram_m[i]; k = ram_k[i]; end
      2'b01: begin i = int'(a % IMG_DEPTH); v = {24'd0, src_m[i]}; k = src_k[i]; end
      2'b10: begin i = int'(a % IMG_DEPTH); v = {24'd0, vram_m[i]}; k = vram_k[i]; end
      default: begin
        if ((a % 4) == 0)      v = {28'd0, buttons};
        else if ((a % 4) == 1) v = {29'd0, err_m, 2'b00};
      end
    endcase
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
    mdl_write(a, d);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] v);
    addr = a; re = 1'b1;
    tick();
    re = 1'b0;
    chk("rvalid pulse", rvalid, 1'b1);
    v = rdata;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a);
    logic [31:0] e, v;
    bit k;
    mdl_read(a, e, k);
    do_read(a, v);
    if (k) chk(nm, v, e);
  endtask

  task automatic disp_chk(input int idx);
    disp_addr = {16'($urandom), 16'(idx)};
    tick();
    if (src_k[idx])  chk("disp_src", disp_src, src_m[idx]);
    if (vram_k[idx]) chk("disp_dst", disp_dst, vram_m[idx]);
  endtask

  task automatic ld_begin(input int s);
    vld_addr = {16'($urandom), 16'(s)};
    vld_req = 1'b1;
    tick();
    vld_req = 1'b0;
  endtask

  // Wait for the load result; 'already' counts cycles spent since the request edge.
  task automatic ld_wait(input int s, input int already);
    int n;
    logic [VEC_W-1:0] e;
    bit known;
    n = already;
    while (!vld_valid && n < 100) begin tick(); n++; end
    chk("load latency", n, LANES + 1);
    known = 1'b1;
    e = '0;
    for (int k = 0; k < LANES; k++) begin
      e[k*8 +: 8] = src_m[(s + k) % IMG_DEPTH];
      if (!src_k[(s + k) % IMG_DEPTH]) known = 1'b0;
    end
    if (known) chk("load data", vld_data, e);
  endtask

  task automatic ld_release();
    vld_ready = 1'b1;
    tick();
    vld_ready = 1'b0;
    chk("vld_valid after accept", vld_valid, 1'b0);
  endtask

  task automatic st_begin(input int s, input logic [VEC_W-1:0] d);
    vst_addr = {16'($urandom), 16'(s)};
    vst_data = d;
    vst_valid = 1'b1;
    chk("vst_ready idle", vst_ready, 1'b1);
    tick();
    vst_valid = 1'b0;
  endtask

  task automatic st_finish(input int s, input logic [VEC_W-1:0] d, input int already);
    int n;
    n = already;
    while (!vst_ready && n < 100) begin tick(); n++; end
    chk("store latency", n, LANES);
    for (int k = 0; k < LANES; k++) begin
      vram_m[(s + k) % IMG_DEPTH] = d[k*8 +: 8];
      vram_k[(s + k) % IMG_DEPTH] = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] v, pre;
    logic [VEC_W-1:0] d;
    int s, r, op;
    logic [1:0] rg;

    rst_n = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0; buttons = 4'b0110;
    vld_req = 1'b0; vld_addr = '0; vld_ready = 1'b0; vst_valid = 1'b0;
    vst_addr = '0; vst_data = '0; disp_addr = '0; err_m = 1'b0;
    tick(); tick();
    chk("reset rdata", rdata, 0);
    chk("reset rvalid", rvalid, 0);
    chk("reset vld_valid", vld_valid, 0);
    chk("reset vld_data", vld_data, 0);
    chk("reset disp_src", disp_src, 0);
    chk("reset disp_dst", disp_dst, 0);
    chk("reset err", err, 0);
    chk("reset vst_ready", vst_ready, 1);
    rst_n = 1'b1;
    tick();

    // Table of scalar vectors
    tbl[0]  = '{1'b1, 32'h0000_0007, 32'h1234_5678, 32'h0};
    tbl[1]  = '{1'b0, 32'h0000_0007, 32'h0,         32'h1234_5678};
    tbl[2]  = '{1'b0, 32'h0000_0407, 32'h0,         32'h1234_5678};
    tbl[3]  = '{1'b1, 32'h8000_0010, 32'h0000_01AB, 32'h0};
    tbl[4]  = '{1'b0, 32'h8000_0010, 32'h0,         32'h0000_00AB};
    tbl[5]  = '{1'b0, 32'h8001_0010, 32'h0,         32'h0000_00AB};
    tbl[6]  = '{1'b1, 32'h0000_03FF, 32'hCAFE_F00D, 32'h0};
    tbl[7]  = '{1'b0, 32'h3FFF_FFFF, 32'h0,         32'hCAFE_F00D};
    tbl[8]  = '{1'b1, 32'hC000_0003, 32'hFFFF_FFFF, 32'h0};
    tbl[9]  = '{1'b0, 32'hC000_0003, 32'h0,         32'h0};
    tbl[10] = '{1'b0, 32'hC000_0002, 32'h0,         32'h0};
    tbl[11] = '{1'b0, 32'hC000_0000, 32'h0,         32'h0000_0006};
    tbl[12] = '{1'b0, 32'hC000_0001, 32'h0,         32'h0};
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].wr) do_write(tbl[i].a, tbl[i].d);
      else begin
        do_read(tbl[i].a, v);
        chk($sformatf("table[%0d]", i), v, tbl[i].exp);
      end
    end

    // RAM write/read, wrap, rvalid single pulse and rdata hold
    do_write(32'h0000_0005, 32'hDEAD_BEEF);
    do_read(32'h0000_0005, v);
    chk("ram5", v, 32'hDEAD_BEEF);
    do_read(32'h0000_0005 + RAM_DEPTH, v);
    chk("ram5 wrap", v, 32'hDEAD_BEEF);
    tick();
    chk("rvalid one cycle", rvalid, 0);
    chk("rdata hold", rdata, 32'hDEAD_BEEF);

    // Vector load of pixels 0..15, with a stalled scalar source read on the way
    for (int i = 0; i < 16; i++) do_write(32'h4000_0000 + i, i);
    ld_begin(0);
    addr = 32'h4000_0005; re = 1'b1;
    #1;
    chk("stall src during load", stall, 1);
    tick();
    re = 1'b0;
    chk("stalled read no rvalid", rvalid, 0);
    ld_wait(0, 1);
`ifndef IOMEM_SRC_WP_EN
    chk("load 0..15", vld_data, 128'h0F0E0D0C0B0A09080706050403020100);
`endif
    d = vld_data;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold valid", vld_valid, 1);
      chk("hold data stable", vld_data, d);
    end
    ld_release();
    do_read(32'hC000_0001, v);
    chk("load busy clear", v[1], 0);

    // Back-to-back load: request while accepting goes straight to LOAD
    ld_begin(3);
    ld_wait(3, 0);
    vld_addr = 32'd7; vld_req = 1'b1; vld_ready = 1'b1;
    tick();
    vld_req = 1'b0; vld_ready = 1'b0;
    chk("restart drops valid", vld_valid, 0);
    ld_wait(7, 0);
    ld_release();

    // Wrapping store at the top of VRAM
    d = 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0;
    st_begin(IMG_DEPTH - 2, d);
    st_finish(IMG_DEPTH - 2, d, 0);
    disp_addr = IMG_DEPTH - 2; tick(); chk("vram top-2", disp_dst, 8'hF0);
    disp_addr = IMG_DEPTH - 1; tick(); chk("vram top-1", disp_dst, 8'hF1);
    disp_addr = 0;             tick(); chk("vram wrap 0", disp_dst, 8'hF2);

    // Scalar VRAM write during a store is stalled; status shows store busy
    do_write(32'h8000_0064, 32'h11);
    d = {4{$urandom}};
    st_begin(200, d);
    addr = 32'h8000_0064; wdata = 32'h22; we = 1'b1;
    #1;
    chk("stall vram during store", stall, 1);
    tick();
    we = 1'b0;
    addr = 32'hC000_0001; re = 1'b1;
    #1;
    chk("no stall io during store", stall, 0);
    tick();
    re = 1'b0;
    chk("status store busy", rdata, {29'd0, err_m, 2'b01});
    st_finish(200, d, 2);
    disp_chk(100);
    chk("stalled write dropped", disp_dst, 8'h11);
    do_write(32'h8000_0064, 32'h22);
    disp_chk(100);
    chk("write after store", disp_dst, 8'h22);

    // Read-during-write on VRAM returns old data on the display port
    addr = 32'h8000_0064; wdata = 32'h33; we = 1'b1; disp_addr = 100;
    tick();
    we = 1'b0;
    mdl_write(32'h8000_0064, 32'h33);
    chk("rdw old data", disp_dst, 8'h22);
    tick();
    chk("rdw new data", disp_dst, 8'h33);

    // I/O bank and error flag
    do_write(32'hC000_0001, 32'h1);
    buttons = 4'b1010;
    do_read(32'hC000_0000, v);
    chk("buttons", v, 32'hA);
    addr = 32'h0000_0009; wdata = 32'h77; we = 1'b1; re = 1'b1;
    tick();
    we = 1'b0; re = 1'b0;
    mdl_write(32'h0000_0009, 32'h77);
    err_m = 1'b1;
    chk("we&re sets err", err, 1);
    chk("we&re no read", rvalid, 0);
    rd_chk("we&re write done", 32'h0000_0009);
    do_read(32'hC000_0001, v);
    chk("status err", v, 32'h4);
    do_write(32'hC000_0001, 32'h1);
    chk("err cleared", err, 0);

    // Source write protection option
`ifdef IOMEM_SRC_WP_EN
    disp_addr = 3; tick(); pre = 32'(disp_src);
    do_write(32'h4000_0003, 32'h55);
    disp_addr = 3; tick();
    chk("wp pixel unchanged", disp_src, pre[7:0]);
    chk("wp err", err, 1);
    do_write(32'hC000_0001, 32'h1);
`else
    pre = 32'h0;
    do_write(32'h4000_0003, 32'h55);
    disp_addr = 3; tick();
    chk("src write lands", disp_src, 8'h55 | pre[7:0]);
    chk("src write no err", err, 0);
`endif

    // Reset in the middle of a store: lanes already written remain
    s = win(IMG_DEPTH, 10);
    d = {4{$urandom}};
    st_begin(s, d);
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    err_m = 1'b0;
    chk("rst store idle", vst_ready, 1);
    chk("rst vld_valid", vld_valid, 0);
    for (int k = 0; k < 5; k++) begin
      vram_m[(s + k) % IMG_DEPTH] = d[k*8 +: 8];
      vram_k[(s + k) % IMG_DEPTH] = 1'b1;
    end
    for (int k = 0; k < 6; k++) disp_chk((s + k) % IMG_DEPTH);

    // Reset in the middle of a load: no result appears
    ld_begin(0);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst load data", vld_data, 0);
    for (int i = 0; i < LANES + 4; i++) tick();
    chk("rst load no valid", vld_valid, 0);

    // Fill a 64-entry window in each region straddling the wrap point
    for (int i = 0; i < 64; i++) begin
      do_write(mk_addr(2'b00, win(RAM_DEPTH, i)), $urandom);
      do_write(mk_addr(2'b01, win(IMG_DEPTH, i)), $urandom);
      do_write(mk_addr(2'b10, win(IMG_DEPTH, i)), $urandom);
    end
    do_write(32'hC000_0001, 32'h1);

    // Randomized operations against the model
    for (int it = 0; it < 250; it++) begin
      op = $urandom_range(0, 5);
      buttons = 4'($urandom);
      case (op)
        0: begin
          rg = 2'($urandom_range(0, 3));
          r = $urandom_range(0, 63);
          if (rg == 2'b11) v = {2'b11, 28'($urandom), 2'($urandom_range(0, 3))};
          else v = mk_addr(rg, win(rg == 2'b00 ? RAM_DEPTH : IMG_DEPTH, r));
          do_write(v, $urandom);
          chk("rand err", err, err_m);
        end
        1: begin
          rg = 2'($urandom_range(0, 3));
          r = $urandom_range(0, 63);
          if (rg == 2'b11) v = {2'b11, 28'($urandom), 2'($urandom_range(0, 3))};
          else v = mk_addr(rg, win(rg == 2'b00 ? RAM_DEPTH : IMG_DEPTH, r));
          rd_chk("rand read", v);
        end
        2: begin
          s = win(IMG_DEPTH, $urandom_range(0, 48));
          ld_begin(s);
          ld_wait(s, 0);
          ld_release();
        end
        3: begin
          s = win(IMG_DEPTH, $urandom_range(0, 48));
          d = {$urandom, $urandom, $urandom, $urandom};
          st_begin(s, d);
          st_finish(s, d, 0);
        end
        4: disp_chk(win(IMG_DEPTH, $urandom_range(0, 63)));
        default: begin
          tick();
          chk("rand err idle", err, err_m);
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iomemory_burst.md
Name: iomemory_burst

Overview:
- Parametrised successor to the single-clock data/vector I/O memory of the interpolation processor.
- Contains four address-decoded regions: scalar data RAM, source-image buffer, destination VRAM and an I/O register bank.
- Adds a multi-lane vector load/store engine with valid/ready handshakes, a 1-cycle-latency scalar port, and a dual-pixel display read port.
- Sits between the processor's memory stage and the video output, all on one clock.

Parameters:
DATA_W, 32, scalar data width.
PIX_W, 8, pixel width in the source and destination buffers.
LANES, 16, pixels per vector load or store (vector width = LANES*PIX_W).
RAM_DEPTH, 1024, scalar RAM words (power of 2).
IMG_DEPTH, 65536, pixels in each of the source buffer and VRAM (power of 2).

Ports:
clk  in  1  system clock, all logic rising-edge.
rst_n  in  1  synchronous active-low reset.
addr  in  32  scalar byte-free word address; region = addr[31:30].
wdata  in  DATA_W  scalar write data.
we  in  1  scalar write strobe.
re  in  1  scalar read strobe.
stall  out  1  scalar access refused this cycle; master holds addr/we/re.
rdata  out  DATA_W  scalar read data.
rvalid  out  1  rdata valid (1 cycle after accepted re).
buttons  in  4  raw button inputs, readable in the I/O region.
vld_req  in  1  vector load request.
vld_addr  in  32  source-buffer start pixel index.
vld_valid  out  1  vector load result valid.
vld_ready  in  1  consumer accepts result.
vld_data  out  LANES*PIX_W  loaded vector; lane 0 in the LSBs.
vst_valid  in  1  vector store request.
vst_ready  out  1  store accepted this cycle.
vst_addr  in  32  VRAM start pixel index.
vst_data  in  LANES*PIX_W  store vector; lane 0 in the LSBs.
disp_addr  in  32  display pixel index.
disp_src  out  PIX_W  source pixel at disp_addr, 1-cycle latency.
disp_dst  out  PIX_W  VRAM pixel at disp_addr, 1-cycle latency.
err  out  1  sticky error flag.

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- Reset values: rdata, rvalid, vld_valid, vld_data, disp_src, disp_dst and err are all 0. Both engines go to IDLE. Memory contents are not cleared.
- Region decode on addr[31:30]:
  - 00: RAM; index = addr mod RAM_DEPTH.
  - 01: source buffer; index = addr mod IMG_DEPTH, PIX_W LSBs of wdata.
  - 10: VRAM; same indexing as the source buffer.
  - 11: I/O bank.
- I/O bank:
  - addr[1:0]=0: read {0, buttons}.
  - addr[1:0]=1: read {0, err, load busy, store busy}.
  - Writing 1 to bit 0 of addr[1:0]=1 clears err.
  - Other offsets read 0; writes to them are ignored.
- Scalar reads: rvalid pulses exactly one cycle after an accepted re. rdata holds its value until the next accepted read. Pixel reads are zero-extended.
- Scalar we and re in the same cycle: perform the write, perform no read, set err.
- Load engine (IDLE, LOAD, HOLD):
  - IDLE, vld_req=1: latch vld_addr, clear lane counter, go to LOAD.
  - LOAD: read one source pixel per cycle into lane k (synchronous read, lane written the following cycle). After LANES reads plus 1 drain cycle, go to HOLD with vld_valid=1.
  - HOLD: vld_data is stable. On vld_valid&&vld_ready go to IDLE. If vld_req is high in that same cycle, go straight to LOAD.
  - Latency from req to valid = LANES+1 cycles.
- Store engine (IDLE, STORE):
  - vst_ready=1 only in IDLE. A handshake latches vst_addr and vst_data and enters STORE.
  - STORE: writes lane k to VRAM[(addr+k) mod IMG_DEPTH], one per cycle. After LANES cycles, return to IDLE.
- Index arithmetic: all indices wrap modulo depth. A burst crossing the top of a buffer continues at index 0.
- Port conflicts:
  - A scalar access to the source region while load is busy, or to VRAM while store is busy, asserts stall combinationally and is not performed.
  - The display port always has its own read port and is never stalled.
- Read-during-write (same index, same cycle): old data is returned.
- Reset asserted mid-burst: engines return to IDLE next edge. Partially written VRAM pixels remain. vld_valid is 0.

Optional Feature:
- Macro: IOMEM_SRC_WP_EN.
- When defined, the source buffer is write-protected from the scalar port: writes to region 01 are dropped and set err.
- When undefined, region 01 is scalar-writable as described above.
- The load engine and display port are unaffected either way.

Test Plan:
- Write 0xDEADBEEF to RAM addr 5, then read addr 5 -> rvalid 1 cycle later with rdata=0xDEADBEEF. Read addr 5+RAM_DEPTH -> same value (wrap).
- Scalar-write pixels 0x00..0x0F to source indices 0..15, then vld_req with addr 0 -> vld_valid at cycle 17, vld_data=0x0F0E...0100. Hold vld_ready=0 for 3 cycles -> data stable. Then ready -> IDLE.
- vst of 0xFF..F0 at IMG_DEPTH-2 -> VRAM[IMG_DEPTH-2]=0xF0, VRAM[IMG_DEPTH-1]=0xF1, VRAM[0]=0xF2; disp_dst reads match 1 cycle after disp_addr.
- Scalar VRAM write during an active store -> stall=1 and VRAM unchanged. Repeat after store done -> write lands.
- buttons=4'b1010, read 0xC0000000 -> rdata=0xA. Assert we&re together -> err=1. Write 1 to 0xC0000001 -> err=0.
- With IOMEM_SRC_WP_EN: write 0x55 to 0x40000003 -> source pixel unchanged, err=1. Without it -> pixel=0x55, err=0.
